// File: rtl/pll_lock_mon_pkg.sv
// Shared definitions for the PLL lock monitor: per-channel state encoding and width.
package pll_lock_mon_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_LOCKED    = 3'd2,
        ST_LOST      = 3'd3,
        ST_FAULT     = 3'd4
    } ch_state_t;

endpackage

// File: rtl/pll_lock_mon_ch.sv
// One monitored PLL: lock synchroniser, edge detect, lock FSM with timeout timer,
// sticky error flags and saturating relock counter.
module pll_lock_mon_ch
    import pll_lock_mon_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int CNT_W        = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_rst_in,
    input  logic                pll_lock,
    input  logic                clr,
    output logic                locked,
    output logic                lock_pulse,
    output logic                err_timeout,
    output logic                err_loss,
    output logic [CNT_W-1:0]    relock_cnt,
    output logic [STATE_W-1:0]  ch_state,
    output logic                timeout_evt,
    output logic                loss_evt
);

    localparam int TIMER_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   edge_reg;
    logic                   sync_out;
    logic                   rise;
    logic                   fall;

    ch_state_t              state_reg;
    ch_state_t              state_next;
    logic [TIMER_W-1:0]     timer_reg;
    logic [TIMER_W-1:0]     timer_next;

    logic                   locked_reg;
    logic                   lock_pulse_reg;
    logic                   err_timeout_reg;
    logic                   err_loss_reg;
    logic [CNT_W-1:0]       relock_reg;

    assign sync_out = sync_reg[SYNC_STAGES-1];
    assign rise     = sync_out & ~edge_reg;
    assign fall     = ~sync_out & edge_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            edge_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_lock};
            edge_reg <= sync_out;
        end
    end

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        timeout_evt = 1'b0;
        loss_evt    = 1'b0;
        if (pll_rst_in) begin
            state_next = ST_RESET;
            timer_next = '0;
        end else begin
            case (state_reg)
                ST_RESET: begin
                    state_next = ST_WAIT_LOCK;
                    timer_next = '0;
                end
                ST_WAIT_LOCK: begin
                    // A rise on the final timer cycle still counts as a clean lock.
                    if (rise) begin
                        state_next = ST_LOCKED;
                    end else if (timer_reg == TIMER_LAST) begin
                        state_next  = ST_FAULT;
                        timeout_evt = 1'b1;
                    end else begin
                        timer_next = timer_reg + TIMER_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (fall) begin
                        state_next = ST_LOST;
                        loss_evt   = 1'b1;
                    end
                end
                ST_LOST: begin
                    state_next = ST_WAIT_LOCK;
                    timer_next = '0;
                end
                ST_FAULT: begin
                    if (clr) begin
                        state_next = ST_WAIT_LOCK;
                        timer_next = '0;
                    end
                end
                default: begin
                    state_next = ST_RESET;
                    timer_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_RESET;
            timer_reg       <= '0;
            locked_reg      <= 1'b0;
            lock_pulse_reg  <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_loss_reg    <= 1'b0;
            relock_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            locked_reg     <= (state_next == ST_LOCKED);
            lock_pulse_reg <= (state_next == ST_LOCKED) && (state_reg != ST_LOCKED);

            // Same-cycle events beat clr so nothing is silently dropped.
            if (timeout_evt) begin
                err_timeout_reg <= 1'b1;
            end else if (clr) begin
                err_timeout_reg <= 1'b0;
            end

            if (loss_evt) begin
                err_loss_reg <= 1'b1;
            end else if (clr) begin
                err_loss_reg <= 1'b0;
            end

            if (loss_evt) begin
                if (clr) begin
                    relock_reg <= CNT_W'(1);
                end else if (relock_reg != CNT_MAX) begin
                    relock_reg <= relock_reg + CNT_W'(1);
                end
            end else if (clr) begin
                relock_reg <= '0;
            end
        end
    end

    assign locked      = locked_reg;
    assign lock_pulse  = lock_pulse_reg;
    assign err_timeout = err_timeout_reg;
    assign err_loss    = err_loss_reg;
    assign relock_cnt  = relock_reg;
    assign ch_state    = state_reg;

endmodule

// File: rtl/pll_lock_mon.sv
// Multi-channel PLL lock monitor: one channel block per PLL plus a global
// saturating error-event counter and an error summary flag.
module pll_lock_mon
    import pll_lock_mon_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int CNT_W        = 4,
    parameter int ERR_CNT_W    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           pll_rst_in,
    input  logic [NUM_CH-1:0]           pll_lock,
    input  logic                        clr,
    output logic [NUM_CH-1:0]           locked,
    output logic [NUM_CH-1:0]           lock_pulse,
    output logic [NUM_CH-1:0]           err_timeout,
    output logic [NUM_CH-1:0]           err_loss,
    output logic                        err_any,
    output logic [NUM_CH*CNT_W-1:0]     relock_cnt,
    output logic [ERR_CNT_W-1:0]        err_cnt,
    output logic [NUM_CH*STATE_W-1:0]   ch_state
);

    localparam int EVT_W = $clog2(2 * NUM_CH + 1);
    localparam int SUM_W = ((ERR_CNT_W > EVT_W) ? ERR_CNT_W : EVT_W) + 1;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic [NUM_CH-1:0]      timeout_evt;
    logic [NUM_CH-1:0]      loss_evt;
    logic [EVT_W-1:0]       evt_count;
    logic [SUM_W-1:0]       err_sum;
    logic [ERR_CNT_W-1:0]   err_cnt_reg;
    logic [ERR_CNT_W-1:0]   err_cnt_next;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            pll_lock_mon_ch #(
                .SYNC_STAGES  (SYNC_STAGES),
                .LOCK_TIMEOUT (LOCK_TIMEOUT),
                .CNT_W        (CNT_W)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .pll_rst_in  (pll_rst_in[gi]),
                .pll_lock    (pll_lock[gi]),
                .clr         (clr),
                .locked      (locked[gi]),
                .lock_pulse  (lock_pulse[gi]),
                .err_timeout (err_timeout[gi]),
                .err_loss    (err_loss[gi]),
                .relock_cnt  (relock_cnt[gi*CNT_W +: CNT_W]),
                .ch_state    (ch_state[gi*STATE_W +: STATE_W]),
                .timeout_evt (timeout_evt[gi]),
                .loss_evt    (loss_evt[gi])
            );
        end
    endgenerate

    always_comb begin
        evt_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            evt_count = evt_count + EVT_W'(timeout_evt[i]) + EVT_W'(loss_evt[i]);
        end
    end

    // clr restarts the count from this cycle's events rather than from zero.
    always_comb begin
        err_sum = (clr ? '0 : SUM_W'(err_cnt_reg)) + SUM_W'(evt_count);
        if (err_sum > SUM_W'(ERR_MAX)) begin
            err_cnt_next = ERR_MAX;
        end else begin
            err_cnt_next = err_sum[ERR_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else begin
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign err_cnt = err_cnt_reg;
    assign err_any = (|err_timeout) | (|err_loss);

endmodule

// File: tb/tb_pll_lock_mon.sv
// Directed scenarios plus a randomized phase, every cycle checked against a
// sample-history reference model of the lock monitor.
module tb_pll_lock_mon;

    localparam int NUM_CH = 2;
    localparam int SS     = 2;
    localparam int LT     = 16;
    localparam int CNT_W  = 4;
    localparam int ECW    = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_CH-1:0]   pll_rst_in;
    logic [NUM_CH-1:0]   pll_lock;
    logic                clr;
    logic [NUM_CH-1:0]   locked;
    logic [NUM_CH-1:0]   lock_pulse;
    logic [NUM_CH-1:0]   err_timeout;
    logic [NUM_CH-1:0]   err_loss;
    logic                err_any;
    logic [NUM_CH*CNT_W-1:0] relock_cnt;
    logic [ECW-1:0]      err_cnt;
    logic [NUM_CH*3-1:0] ch_state;

    int total = 0;
    int bad   = 0;

    pll_lock_mon #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SS), .LOCK_TIMEOUT(LT),
        .CNT_W(CNT_W), .ERR_CNT_W(ECW)
    ) dut (
        .clk(clk), .rst(rst), .pll_rst_in(pll_rst_in), .pll_lock(pll_lock),
        .clr(clr), .locked(locked), .lock_pulse(lock_pulse),
        .err_timeout(err_timeout), .err_loss(err_loss), .err_any(err_any),
        .relock_cnt(relock_cnt), .err_cnt(err_cnt), .ch_state(ch_state)
    );

    always #5 clk = ~clk;

    // Reference model. hist[ch][k] is the pll_lock value sampled k+1 edges ago.
    int m_state [NUM_CH];
    int m_timer [NUM_CH];
    bit m_pulse [NUM_CH];
    bit m_et    [NUM_CH];
    bit m_el    [NUM_CH];
    int m_rel   [NUM_CH];
    int m_err;
    bit hist [NUM_CH][SS+1];

    task automatic model_edge();
        int ev;
        ev = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit s, e, rise, fall, tev, lev;
            int prev, ns;
            if (rst) begin
                m_state[ch] = 0; m_timer[ch] = 0; m_pulse[ch] = 0;
                m_et[ch] = 0; m_el[ch] = 0; m_rel[ch] = 0;
                for (int k = 0; k <= SS; k++) hist[ch][k] = 0;
            end else begin
                s = hist[ch][SS-1];
                e = hist[ch][SS];
                rise = s && !e;
                fall = !s && e;
                prev = m_state[ch];
                ns = prev;
                tev = 0;
                lev = 0;
                if (pll_rst_in[ch]) begin
                    ns = 0; m_timer[ch] = 0;
                end else if (prev == 0 || prev == 3) begin
                    ns = 1; m_timer[ch] = 0;
                end else if (prev == 1) begin
                    if (rise) ns = 2;
                    else if (m_timer[ch] == LT - 1) begin ns = 4; tev = 1; end
                    else m_timer[ch]++;
                end else if (prev == 2) begin
                    if (fall) begin ns = 3; lev = 1; end
                end else if (prev == 4) begin
                    if (clr) begin ns = 1; m_timer[ch] = 0; end
                end
                m_pulse[ch] = (ns == 2) && (prev != 2);
                m_state[ch] = ns;
                m_et[ch] = tev ? 1'b1 : (clr ? 1'b0 : m_et[ch]);
                m_el[ch] = lev ? 1'b1 : (clr ? 1'b0 : m_el[ch]);
                if (lev) m_rel[ch] = clr ? 1 : ((m_rel[ch] < 15) ? m_rel[ch] + 1 : 15);
                else if (clr) m_rel[ch] = 0;
                ev += int'(tev) + int'(lev);
                for (int k = SS; k > 0; k--) hist[ch][k] = hist[ch][k-1];
                hist[ch][0] = pll_lock[ch];
            end
        end
        if (rst) m_err = 0;
        else begin
            m_err = (clr ? 0 : m_err) + ev;
            if (m_err > 7) m_err = 7;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NUM_CH-1:0] e_lk, e_pu, e_et, e_el;
        logic [NUM_CH*CNT_W-1:0] e_rc;
        logic [NUM_CH*3-1:0] e_st;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            e_lk[ch] = (m_state[ch] == 2);
            e_pu[ch] = m_pulse[ch];
            e_et[ch] = m_et[ch];
            e_el[ch] = m_el[ch];
            e_rc[ch*CNT_W +: CNT_W] = CNT_W'(m_rel[ch]);
            e_st[ch*3 +: 3] = 3'(m_state[ch]);
        end
        chk("locked", 32'(locked), 32'(e_lk));
        chk("lock_pulse", 32'(lock_pulse), 32'(e_pu));
        chk("err_timeout", 32'(err_timeout), 32'(e_et));
        chk("err_loss", 32'(err_loss), 32'(e_el));
        chk("err_any", 32'(err_any), 32'((|e_et) | (|e_el)));
        chk("relock_cnt", 32'(relock_cnt), 32'(e_rc));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
        chk("ch_state", 32'(ch_state), 32'(e_st));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int pulses;
        bit seen_lost;

        rst = 1'b1; pll_rst_in = 2'b11; pll_lock = 2'b00; clr = 1'b0;
        ticks(2);
        chk("reset_state", 32'(ch_state), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        ticks(2);

        // Normal lock on ch0: locked on the 3rd edge after pll_lock goes high.
        pll_rst_in[0] = 1'b0;
        ticks(5);
        pll_lock[0] = 1'b1;
        tick(); chk("lock_edge1", 32'(locked[0]), 32'd0);
        tick(); chk("lock_edge2", 32'(locked[0]), 32'd0);
        tick(); chk("lock_edge3", 32'(locked[0]), 32'd1);
        chk("lock_pulse_on", 32'(lock_pulse[0]), 32'd1);
        tick(); chk("lock_pulse_off", 32'(lock_pulse[0]), 32'd0);
        chk("lock_no_err", 32'(err_any), 32'd0);

        // Timeout on ch1: 16 cycles in WAIT_LOCK then FAULT.
        pll_rst_in[1] = 1'b0;
        tick();
        ticks(15);
        chk("to_still_wait", 32'(ch_state[5:3]), 32'd1);
        tick();
        chk("to_fault", 32'(ch_state[5:3]), 32'd4);
        chk("to_flag", 32'(err_timeout[1]), 32'd1);
        chk("to_err_cnt", 32'(err_cnt), 32'd1);
        ticks(3);
        chk("to_fault_hold", 32'(ch_state[5:3]), 32'd4);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_wait", 32'(ch_state[5:3]), 32'd1);
        chk("clr_flag", 32'(err_timeout[1]), 32'd0);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        pll_lock[1] = 1'b1;
        ticks(4);
        chk("ch1_locked", 32'(locked[1]), 32'd1);

        // Loss and relock on ch0.
        pulses = 0; seen_lost = 0;
        pll_lock[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) pll_lock[0] = 1'b1;
            tick();
            if (lock_pulse[0]) pulses++;
            if (ch_state[2:0] == 3'd3) seen_lost = 1;
        end
        chk("loss_seen_lost", 32'(seen_lost), 32'd1);
        chk("loss_flag", 32'(err_loss[0]), 32'd1);
        chk("loss_relock", 32'(relock_cnt[3:0]), 32'd1);
        chk("loss_repulse", 32'(pulses), 32'd1);
        chk("loss_relocked", 32'(locked[0]), 32'd1);
        chk("loss_err_cnt", 32'(err_cnt), 32'd1);

        // clr in the same cycle as a loss: the event wins.
        pll_lock[0] = 1'b0;
        ticks(2);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clrloss_flag", 32'(err_loss[0]), 32'd1);
        chk("clrloss_err_cnt", 32'(err_cnt), 32'd1);
        chk("clrloss_relock", 32'(relock_cnt[3:0]), 32'd1);
        pll_lock[0] = 1'b1;
        ticks(6);

        // Simultaneous losses and saturation of both counters.
        clr = 1'b1; tick(); clr = 1'b0;
        for (int it = 0; it < 17; it++) begin
            pll_lock = 2'b00; ticks(4);
            pll_lock = 2'b11; ticks(6);
            if (it == 2) chk("sat_err6", 32'(err_cnt), 32'd6);
            if (it == 3) chk("sat_err7", 32'(err_cnt), 32'd7);
            if (it == 14) chk("sat_rel15", 32'(relock_cnt), 32'hFF);
            if (it == 16) chk("sat_rel_hold", 32'(relock_cnt), 32'hFF);
        end
        chk("sat_err_hold", 32'(err_cnt), 32'd7);

        // pll_rst_in at timer=15 beats the timeout.
        clr = 1'b1; tick(); clr = 1'b0;
        pll_rst_in[1] = 1'b1; pll_lock[1] = 1'b0; tick();
        pll_rst_in[1] = 1'b0; tick();
        ticks(15);
        chk("prio_wait15", 32'(ch_state[5:3]), 32'd1);
        pll_rst_in[1] = 1'b1; tick();
        chk("prio_reset", 32'(ch_state[5:3]), 32'd0);
        chk("prio_no_to", 32'(err_timeout[1]), 32'd0);
        chk("prio_err_cnt", 32'(err_cnt), 32'd0);

        // Randomized phase against the model.
        for (int c = 0; c < 400; c++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(5) == 0) pll_lock[ch] = ~pll_lock[ch];
                if (pll_rst_in[ch]) begin
                    if ($urandom_range(3) == 0) pll_rst_in[ch] = 1'b0;
                end else if ($urandom_range(39) == 0) pll_rst_in[ch] = 1'b1;
            end
            clr = ($urandom_range(29) == 0);
            rst = ($urandom_range(149) == 0);
            tick();
        end
        clr = 1'b0; rst = 1'b0;

        // rst while LOCKED, landing on the cycle a loss would be detected.
        rst = 1'b1; tick(); rst = 1'b0;
        pll_rst_in = 2'b00; pll_lock = 2'b00;
        ticks(3);
        pll_lock[0] = 1'b1;
        ticks(6);
        chk("rst_pre_locked", 32'(locked[0]), 32'd1);
        pll_lock[0] = 1'b0;
        ticks(2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_pulse", 32'(lock_pulse), 32'd0);
        chk("rst_flags", 32'({err_timeout, err_loss, err_any}), 32'd0);
        chk("rst_counts", 32'({relock_cnt, err_cnt}), 32'd0);
        chk("rst_state", 32'(ch_state), 32'd0);
        ticks(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_mon.md
PLL_LOCK_MON -- requirements
Module: pll_lock_mon

Interface
REQ-001 Parameter NUM_CH, default 2: number of monitored PLLs, legal range 1..8.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth on each pll_lock input, legal range 2..4.
REQ-003 Parameter LOCK_TIMEOUT, default 65536: maximum clk cycles allowed from PLL reset release to lock, legal range 2..2^20.
REQ-004 Parameter CNT_W, default 4: width of each per-channel relock counter.
REQ-005 Parameter ERR_CNT_W, default 3: width of the global error counter.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset.
REQ-007 clk, input, 1: sole clock.
REQ-008 rst, input, 1: synchronous, active-high reset.
REQ-009 pll_rst_in, input, NUM_CH: reset currently driven to each PLL, high = PLL held in reset.
REQ-010 pll_lock, input, NUM_CH: raw PLL lock outputs, asynchronous to clk.
REQ-011 clr, input, 1: single-cycle pulse that clears the sticky errors and all counters.
REQ-012 locked, output, NUM_CH: channel is in state LOCKED.
REQ-013 lock_pulse, output, NUM_CH: one-cycle pulse on each entry into LOCKED.
REQ-014 err_timeout, output, NUM_CH: sticky flag, lock timeout occurred.
REQ-015 err_loss, output, NUM_CH: sticky flag, lock lost while in LOCKED.
REQ-016 err_any, output, 1: OR of all err_timeout and err_loss bits.
REQ-017 relock_cnt, output, NUM_CH*CNT_W: per-channel loss count; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-018 err_cnt, output, ERR_CNT_W: global count of error events, saturating.
REQ-019 ch_state, output, NUM_CH*3: per-channel state encoding, provided for debug.

Function
REQ-020 Each pll_lock bit SHALL pass through a SYNC_STAGES flop chain.
- Edge detection SHALL compare the synchroniser output against one further register.
- locked SHALL assert on the (SYNC_STAGES+1)th clk edge, counting the first edge that samples pll_lock high as edge 1.
REQ-021 Per-channel FSM states:
- RESET=0, WAIT_LOCK=1, LOCKED=2, LOST=3, FAULT=4.
REQ-022 pll_rst_in[i]=1 SHALL force RESET from any state. This has the highest priority.
- The channel timer SHALL be cleared.
REQ-023 RESET -> WAIT_LOCK on the first cycle pll_rst_in[i]=0; timer = 0.
REQ-024 WAIT_LOCK:
- The timer SHALL increment by 1 per cycle.
- A detected rise SHALL cause a transition to LOCKED.
- Otherwise, when timer == LOCK_TIMEOUT-1, the channel SHALL go to FAULT and set err_timeout[i].
- A rise in that same cycle SHALL win (LOCKED, no error).
REQ-025 LOCKED: a detected fall SHALL cause a transition to LOST.
- err_loss[i] SHALL be set.
- relock_cnt[i] SHALL increment, saturating at 2^CNT_W-1.
REQ-026 LOST -> WAIT_LOCK unconditionally on the next cycle; timer = 0.
REQ-027 FAULT SHALL hold until pll_rst_in[i]=1 or clr=1. On clr the channel SHALL go to WAIT_LOCK with timer = 0.
REQ-028 Each cycle, err_cnt SHALL add the number of new error events (timeouts plus losses) across all channels, saturating at 2^ERR_CNT_W-1.
REQ-029 clr SHALL zero err_timeout, err_loss, relock_cnt and err_cnt.
- An event in the same cycle as clr SHALL win: its flag is set, err_cnt = that cycle's event count, and relock_cnt = 1 for a loss.
REQ-030 The timer width SHALL be $clog2(LOCK_TIMEOUT+1). The timer SHALL never wrap.
REQ-031 All outputs SHALL be registered, except err_any, which is an OR of registers.

Reset
REQ-032 rst=1 SHALL set the following:
- all synchroniser and edge flops to 0;
- all FSMs to RESET;
- all timers, counters and flags to 0;
- locked = 0, lock_pulse = 0, ch_state = 0.
REQ-033 rst asserted mid-operation, in any state, SHALL take effect on the next edge. No lock_pulse or error event SHALL be produced in that cycle.

Structure
REQ-034 Package pll_lock_mon_pkg SHALL hold the state enum/encoding and the STATE_W = 3 constant.
REQ-035 Sub-module pll_lock_mon_ch SHALL contain the synchroniser, edge detect, FSM, timer and relock counter for one channel.
- The top level SHALL instantiate it NUM_CH times via generate.
- The top level SHALL own the err_cnt adder/saturation and err_any.

Verification
Bench parameters for all scenarios: NUM_CH=2, SYNC_STAGES=2, LOCK_TIMEOUT=16, CNT_W=4, ERR_CNT_W=3.
REQ-036 Normal lock:
- Stimulus: release pll_rst_in[0], raise pll_lock[0] 5 cycles later.
- Response: locked[0]=1 on the 3rd edge after sampling; lock_pulse[0] high exactly 1 cycle; no errors.
REQ-037 Timeout:
- Stimulus: release pll_rst_in[1], pll_lock[1] held at 0.
- Response: ch_state[1]=FAULT after 16 cycles in WAIT_LOCK; err_timeout[1]=1; err_cnt=1; a clr pulse returns the channel to WAIT_LOCK.
REQ-038 Loss and relock:
- Stimulus: ch0 LOCKED, pll_lock[0] low for 4 cycles.
- Response: LOCKED -> LOST -> WAIT_LOCK -> LOCKED; err_loss[0]=1; relock_cnt[0]=1; a second lock_pulse.
REQ-039 Simultaneous events and saturation:
- Stimulus: both channels lose lock in the same cycle, starting from err_cnt=6.
- Response: err_cnt=7 (saturated); relock_cnt at 15 stays 15.
REQ-040 Priorities:
- Stimulus A: clr in the same cycle as a loss. Response: err_loss=1, err_cnt=1.
- Stimulus B: pll_rst_in asserted at timer=15. Response: RESET, no timeout.
- Stimulus C: rst while LOCKED. Response: all outputs 0 on the next edge.
